nios2_core: RTL and testbench

- Single-cycle, 32-bit processor core executing a small Nios II-style integer subset.
- The instruction word is supplied externally on every clock (no internal instruction memory).
- The core keeps the PC, a 32x32 register file and a word-addressed data memory, and executes one instruction per rising clock edge.
- Debug/observation ports expose the PC, register writeback, memory stores and a host preload path for the data memory. It sits under the course-level top/testbench as the datapath under test.

---
 rtl/nios2_core.sv | 143 ++++++++++++++
 tb/tb_nios2_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_core.sv
// Single-cycle Nios II-style integer core: add/mul/addi/ldw/stw/bgt/br with
// an external instruction stream, an internal register file and a word-addressed data memory.
module nios2_core #(
  parameter int DMEM_WORDS = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               host_we,
  input  logic [DMEM_AW-1:0] host_addr,
  input  logic [31:0]        host_wdata,
  output logic [31:0]        pc,
  output logic               wb_en,
  output logic [4:0]         wb_addr,
  output logic [31:0]        wb_data,
  output logic               st_en,
  output logic [31:0]        st_addr,
  output logic [31:0]        st_data
);

  localparam logic [5:0] OP_RTYPE = 6'h3A;
  localparam logic [5:0] OP_ADDI  = 6'h04;
  localparam logic [5:0] OP_LDW   = 6'h17;
  localparam logic [5:0] OP_STW   = 6'h15;
  localparam logic [5:0] OP_BGT   = 6'h16;
  localparam logic [5:0] OP_BR    = 6'h06;
  localparam logic [5:0] FN_ADD   = 6'h31;
  localparam logic [5:0] FN_MUL   = 6'h27;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] mem_q [DMEM_WORDS];

  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        st_en_q, st_en_d;
  logic [31:0] st_addr_q, st_addr_d;
  logic [31:0] st_data_q, st_data_d;

  logic [4:0]  fieldA, fieldB, fieldC;
  logic [5:0]  opcode, func;
  logic [31:0] immSext, opA, opB, effAddr, pcPlus4;
  logic [DMEM_AW-1:0] memIdx;

  assign fieldA  = instr[31:27];
  assign fieldB  = instr[26:22];
  assign fieldC  = instr[21:17];
  assign func    = instr[11:6];
  assign opcode  = instr[5:0];
  assign immSext = {{16{instr[21]}}, instr[21:6]};

  // r0 is hardwired to zero on the read side; its storage is never written.
  assign opA     = (fieldA == 5'd0) ? 32'd0 : rf_q[fieldA];
  assign opB     = (fieldB == 5'd0) ? 32'd0 : rf_q[fieldB];
  assign effAddr = opA + immSext;
  assign memIdx  = effAddr[DMEM_AW+1:2];
  assign pcPlus4 = pc_q + 32'd4;

  always_comb begin
    pc_d      = pcPlus4;
    wb_en_d   = 1'b0;
    wb_addr_d = 5'd0;
    wb_data_d = 32'd0;
    st_en_d   = 1'b0;
    st_addr_d = 32'd0;
    st_data_d = 32'd0;
    case (opcode)
      OP_RTYPE: begin
        if (func == FN_ADD) begin
          wb_en_d   = 1'b1;
          wb_addr_d = fieldC;
          wb_data_d = opA + opB;
        end else if (func == FN_MUL) begin
          wb_en_d   = 1'b1;
          wb_addr_d = fieldC;
          wb_data_d = opA * opB;
        end
      end
      OP_ADDI: begin
        wb_en_d   = 1'b1;
        wb_addr_d = fieldB;
        wb_data_d = effAddr;
      end
      OP_LDW: begin
        wb_en_d   = 1'b1;
        wb_addr_d = fieldB;
        wb_data_d = mem_q[memIdx];
      end
      OP_STW: begin
        st_en_d   = 1'b1;
        st_addr_d = effAddr;
        st_data_d = opB;
      end
      OP_BGT: begin
        if ($signed(opA) > $signed(opB)) pc_d = pcPlus4 + immSext;
      end
      OP_BR: pc_d = pcPlus4 + immSext;
      default: ;
    endcase
    // A write aimed at r0 is dropped and must not show up on the writeback port.
    if (wb_addr_d == 5'd0) begin
      wb_en_d   = 1'b0;
      wb_data_d = 32'd0;
    end
  end

  // The host write is issued after the store so it wins on a same-word collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= 32'd0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
      st_en_q   <= 1'b0;
      st_addr_q <= 32'd0;
      st_data_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      for (int j = 0; j < DMEM_WORDS; j++) mem_q[j] <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      st_en_q   <= st_en_d;
      st_addr_q <= st_addr_d;
      st_data_q <= st_data_d;
      if (wb_en_d) rf_q[wb_addr_d] <= wb_data_d;
      if (st_en_d) mem_q[memIdx] <= opB;
      if (host_we) mem_q[host_addr] <= host_wdata;
    end
  end

  assign pc      = pc_q;
  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign st_en   = st_en_q;
  assign st_addr = st_addr_q;
  assign st_data = st_data_q;

endmodule

// File: tb/tb_nios2_core.sv
// Bench for nios2_core: directed program steps plus random instruction mix,
// checked against an architectural model of pc, registers and memory.
module tb_nios2_core;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        st_en;
  logic [31:0] st_addr;
  logic [31:0] st_data;

  int checks = 0;
  int errors = 0;

  nios2_core #(.DMEM_WORDS(256), .DMEM_AW(8)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .pc(pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .st_en(st_en), .st_addr(st_addr), .st_data(st_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model state and the outputs it predicts for the last edge
  logic [31:0] mRegs [32];
  logic [31:0] mMem [256];
  logic [31:0] mPc;
  logic        eWbEn;
  logic [4:0]  eWbAddr;
  logic [31:0] eWbData;
  logic        eStEn;
  logic [31:0] eStAddr;
  logic [31:0] eStData;

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input int imm);
    logic [15:0] i16;
    i16 = 16'(imm);
    return {a, b, i16, op};
  endfunction

  function automatic logic [31:0] encR(input logic [5:0] fn, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] c);
    return {a, b, c, 5'd0, fn, 6'h3A};
  endfunction

  function automatic logic [7:0] wordOf(input logic [31:0] byteAddr);
    return 8'((byteAddr / 32'd4) % 32'd256);
  endfunction

  task automatic modelStep(input logic [31:0] ins, input bit r, input bit hwe,
                           input logic [7:0] ha, input logic [31:0] hd);
    logic [31:0] ra, rb, simm, ea, val, nextPc;
    logic [4:0]  dest;
    bit wr, st;
    eWbEn = 0; eWbAddr = 0; eWbData = 0; eStEn = 0; eStAddr = 0; eStData = 0;
    if (r) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 0;
      for (int i = 0; i < 256; i++) mMem[i] = 0;
      mPc = 0;
      return;
    end
    ra = mRegs[ins[31:27]];
    rb = mRegs[ins[26:22]];
    simm = 32'($signed(ins[21:6]));
    ea = ra + simm;
    nextPc = mPc + 4;
    dest = ins[26:22];
    val = 0; wr = 0; st = 0;
    case (ins[5:0])
      6'h3A: begin
        dest = ins[21:17];
        if (ins[11:6] == 6'h31) begin wr = 1; val = ra + rb; end
        else if (ins[11:6] == 6'h27) begin wr = 1; val = ra * rb; end
      end
      6'h04: begin wr = 1; val = ea; end
      6'h17: begin wr = 1; val = mMem[wordOf(ea)]; end
      6'h15: st = 1;
      6'h16: if ($signed(ra) > $signed(rb)) nextPc = mPc + 4 + simm;
      6'h06: nextPc = mPc + 4 + simm;
      default: ;
    endcase
    if (wr && dest != 0) begin
      mRegs[dest] = val;
      eWbEn = 1; eWbAddr = dest; eWbData = val;
    end
    if (st) begin
      mMem[wordOf(ea)] = rb;
      eStEn = 1; eStAddr = ea; eStData = rb;
    end
    if (hwe) mMem[ha] = hd;
    mPc = nextPc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict, drive, sample 1 ns after the edge, compare everything
  task automatic applyStimulus(input logic [31:0] ins, input bit r = 0, input bit hwe = 0,
                               input logic [7:0] ha = 0, input logic [31:0] hd = 0);
    modelStep(ins, r, hwe, ha, hd);
    instr = ins; rst = r; host_we = hwe; host_addr = ha; host_wdata = hd;
    @(posedge clk);
    #1;
    checkOutput("pc", pc, mPc);
    checkOutput("wb_en", {31'd0, wb_en}, {31'd0, eWbEn});
    checkOutput("wb_addr", {27'd0, wb_addr}, {27'd0, eWbAddr});
    checkOutput("wb_data", wb_data, eWbData);
    checkOutput("st_en", {31'd0, st_en}, {31'd0, eStEn});
    checkOutput("st_addr", st_addr, eStAddr);
    checkOutput("st_data", st_data, eStData);
    host_we = 0;
  endtask

  localparam logic [5:0] ADDI = 6'h04, LDW = 6'h17, STW = 6'h15, BGT = 6'h16, BR = 6'h06;
  localparam logic [5:0] FADD = 6'h31, FMUL = 6'h27;

  logic [31:0] prog [13];
  logic [31:0] vecA [6];
  logic [31:0] vecB [6];
  logic [31:0] dotSum;
  logic [31:0] pcBefore;
  int steps;

  initial begin
    instr = 0; rst = 1; host_we = 0; host_addr = 0; host_wdata = 0;
    for (int i = 0; i < 32; i++) mRegs[i] = 0;
    for (int i = 0; i < 256; i++) mMem[i] = 0;
    mPc = 0;
    applyStimulus(32'h0, 1);
    applyStimulus(32'h0, 1);

    // addi r2,r0,5 then addi r4,r2,-1
    applyStimulus(32'h00800144);
    checkOutput("addi_pc", pc, 32'd4);
    checkOutput("addi_wb", wb_data, 32'd5);
    applyStimulus(32'h113FFFC4);
    checkOutput("subi_wb", wb_data, 32'd4);

    // add / mul including the wrapping product
    applyStimulus(encI(ADDI, 0, 5, 3));
    applyStimulus(encI(ADDI, 0, 8, 7));
    applyStimulus(32'h2A0A0C7A);
    checkOutput("add_wb", wb_data, 32'd10);
    applyStimulus(encI(ADDI, 0, 6, 6));
    applyStimulus(encI(ADDI, 0, 7, 7));
    applyStimulus(32'h31D009FA);
    checkOutput("mul_wb", wb_data, 32'd42);
    applyStimulus(encI(ADDI, 0, 6, 256));
    applyStimulus(encR(FMUL, 6, 6, 6));
    applyStimulus(encI(ADDI, 6, 7, 0));
    applyStimulus(32'h31D009FA);
    checkOutput("mul_wrap", wb_data, 32'd0);

    // host preload, load, store, reload
    applyStimulus(encR(FADD, 0, 0, 4), 0, 1, 8'd0, 32'd3);
    applyStimulus(encI(ADDI, 0, 4, 0));
    applyStimulus(32'h21000017);
    checkOutput("ldw_wb", wb_data, 32'd3);
    applyStimulus(encI(ADDI, 0, 5, 42));
    applyStimulus(32'h01400015);
    checkOutput("stw_data", st_data, 32'd42);
    applyStimulus(encI(LDW, 0, 9, 0));
    checkOutput("ldw_after_stw", wb_data, 32'd42);

    // bgt taken / not taken (signed), br forward and self-loop
    applyStimulus(encI(ADDI, 0, 4, 1));
    pcBefore = pc;
    applyStimulus(encI(BGT, 4, 0, -32));
    checkOutput("bgt_taken", pc, pcBefore - 32'd28);
    applyStimulus(encI(ADDI, 0, 4, 0));
    applyStimulus(encI(BGT, 4, 0, -32));
    applyStimulus(encI(ADDI, 0, 4, -1));
    pcBefore = pc;
    applyStimulus(encI(BGT, 4, 0, -32));
    checkOutput("bgt_signed", pc, pcBefore + 32'd4);
    applyStimulus(32'h00000006);
    pcBefore = pc;
    applyStimulus(encI(BR, 0, 0, -4));
    checkOutput("br_self", pc, pcBefore);

    // writes to r0 and an unknown opcode produce nothing
    applyStimulus(encI(ADDI, 3, 0, 77));
    applyStimulus(encR(FADD, 5, 5, 0));
    applyStimulus(32'h0000003F);

    // host write and stw to the same word in one cycle
    applyStimulus(encI(ADDI, 0, 10, 40));
    applyStimulus(encI(STW, 0, 10, 20), 0, 1, 8'd5, 32'hCAFE_F00D);
    applyStimulus(encI(LDW, 0, 11, 20));
    checkOutput("host_wins", wb_data, 32'hCAFE_F00D);

    // mid-program reset with a host write that must be ignored
    applyStimulus(encI(ADDI, 0, 12, 9), 1, 1, 8'd5, 32'h1234);
    checkOutput("rst_pc", pc, 32'd0);
    for (int k = 1; k < 32; k++) applyStimulus(encI(ADDI, k[4:0], k[4:0], 1));
    for (int k = 0; k < 8; k++) applyStimulus(encI(LDW, 0, 1, k * 4));

    // dot product of two host-preloaded 6-element arrays
    prog[0]  = encI(ADDI, 0, 1, 64);
    prog[1]  = encI(ADDI, 0, 2, 128);
    prog[2]  = encI(ADDI, 0, 3, 6);
    prog[3]  = encI(ADDI, 0, 4, 0);
    prog[4]  = encI(LDW, 1, 5, 0);
    prog[5]  = encI(LDW, 2, 6, 0);
    prog[6]  = encR(FMUL, 5, 6, 7);
    prog[7]  = encR(FADD, 4, 7, 4);
    prog[8]  = encI(ADDI, 1, 1, 4);
    prog[9]  = encI(ADDI, 2, 2, 4);
    prog[10] = encI(ADDI, 3, 3, -1);
    prog[11] = encI(BGT, 3, 0, -32);
    prog[12] = encI(STW, 0, 4, 0);
    applyStimulus(32'h0, 1);
    dotSum = 0;
    for (int i = 0; i < 6; i++) begin
      vecA[i] = $urandom_range(1000);
      vecB[i] = $urandom_range(1000);
      dotSum += vecA[i] * vecB[i];
      applyStimulus(32'h0000003F, 0, 1, 8'(16 + i), vecA[i]);
      applyStimulus(32'h0000003F, 0, 1, 8'(32 + i), vecB[i]);
    end
    applyStimulus(encI(BR, 0, 0, -52));
    steps = 0;
    while (mPc != 32'd48 && steps < 200) begin
      applyStimulus(prog[mPc / 4]);
      steps++;
    end
    checkOutput("dot_bound", 32'(steps < 200), 32'd1);
    applyStimulus(prog[12]);
    checkOutput("dot_sum", st_data, dotSum);
    applyStimulus(encI(LDW, 0, 9, 0));
    checkOutput("dot_mem", wb_data, dotSum);

    // random instruction mix with occasional host writes and resets
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      int sel;
      sel = $urandom_range(9);
      case (sel)
        0, 1: ins = encR(($urandom_range(1) != 0) ? FADD : FMUL, 5'($urandom_range(7)),
                         5'($urandom_range(7)), 5'($urandom_range(7)));
        2, 3: ins = encI(ADDI, 5'($urandom_range(7)), 5'($urandom_range(7)),
                         int'($urandom_range(65535)) - 32768);
        4: ins = encI(LDW, 5'($urandom_range(7)), 5'($urandom_range(7)), $urandom_range(2047));
        5: ins = encI(STW, 5'($urandom_range(7)), 5'($urandom_range(7)), $urandom_range(2047));
        6: ins = encI(BGT, 5'($urandom_range(7)), 5'($urandom_range(7)),
                      int'($urandom_range(255)) - 128);
        7: ins = encI(BR, 0, 0, int'($urandom_range(255)) - 128);
        default: ins = $urandom;
      endcase
      applyStimulus(ins, ($urandom_range(99) == 0), ($urandom_range(3) == 0),
                    8'($urandom_range(255)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
